// File: rtl/merge_rr_4p.sv
// Two-channel 4-phase bundled-data merge: round-robin arbitration into a small FIFO,
// drained by a single 4-phase output port that tags each word with its source.
module merge_rr_4p #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             L0_req,
   input  logic [WIDTH-1:0] L0_data,
   output logic             L0_ack,
   input  logic             L1_req,
   input  logic [WIDTH-1:0] L1_data,
   output logic             L1_ack,
   output logic             R_req,
   output logic [WIDTH-1:0] R_data,
   output logic             R_src,
   input  logic             R_ack
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, ACKED} in_state_t;
   typedef enum logic [1:0] {OIDLE, OREQ, ORTZ} out_state_t;

   in_state_t        st0, st1;
   out_state_t       ost;
   logic [WIDTH:0]   mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             rr;

   logic             pop, space, req0, req1, grant0, grant1, push;
   logic [WIDTH:0]   push_word;

   // A pop on this edge frees its slot for a push on the same edge.
   assign pop       = (ost == OREQ) && R_ack;
   assign space     = (count < CW'(DEPTH)) || pop;
   assign req0      = (st0 == IDLE) && L0_req;
   assign req1      = (st1 == IDLE) && L1_req;
   assign grant0    = space && req0 && (!req1 || !rr);
   assign grant1    = space && req1 && (!req0 ||  rr);
   assign push      = grant0 || grant1;
   assign push_word = grant1 ? {1'b1, L1_data} : {1'b0, L0_data};

   // NOTE: storage array is left out of reset; count and pointers alone define validity,
   // and keeping it reset-free lets it map onto plain registers or RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_word;
   end

   // NOTE: all sequential state uses non-blocking assignments so every branch sees
   // the pre-edge values, exactly like the hardware.
   always_ff @(posedge clk) begin
      if (rst) begin
         st0    <= IDLE;
         st1    <= IDLE;
         L0_ack <= 1'b0;
         L1_ack <= 1'b0;
         ost    <= OIDLE;
         R_req  <= 1'b0;
         R_data <= '0;
         R_src  <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rr     <= 1'b0;
      end else begin
         case (st0)
            IDLE:  if (grant0)  begin st0 <= ACKED; L0_ack <= 1'b1; end
            ACKED: if (!L0_req) begin st0 <= IDLE;  L0_ack <= 1'b0; end
         endcase

         case (st1)
            IDLE:  if (grant1)  begin st1 <= ACKED; L1_ack <= 1'b1; end
            ACKED: if (!L1_req) begin st1 <= IDLE;  L1_ack <= 1'b0; end
         endcase

         // Only a contested grant moves the pointer, to the channel that lost.
         if (req0 && req1 && space) rr <= ~rr;

         if (push) wr_ptr <= wr_ptr + PW'(1);

         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);

         case (ost)
            OIDLE: if (count != '0) begin
               R_data <= mem[rd_ptr][WIDTH-1:0];
               R_src  <= mem[rd_ptr][WIDTH];
               R_req  <= 1'b1;
               ost    <= OREQ;
            end
            OREQ: if (R_ack) begin
               R_req  <= 1'b0;
               rd_ptr <= rd_ptr + PW'(1);
               ost    <= ORTZ;
            end
            ORTZ: if (!R_ack) ost <= OIDLE;
            default: ost <= OIDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_merge_rr_4p.sv
// Directed bench for merge_rr_4p: single source, contention, fairness, full buffer,
// push+pop at full and mid-transfer reset, with hand-computed expectations.
module tb_merge_rr_4p;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       L0_req = 1'b0, L1_req = 1'b0;
   logic [7:0] L0_data = '0, L1_data = '0;
   logic       L0_ack, L1_ack, R_req, R_src;
   logic [7:0] R_data;
   logic       R_ack;
   logic       cons_en = 1'b0, cons_ack = 1'b0, man_ack = 1'b0;

   assign R_ack = cons_en ? cons_ack : man_ack;

   merge_rr_4p #(.WIDTH(8), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .L0_req(L0_req), .L0_data(L0_data), .L0_ack(L0_ack),
      .L1_req(L1_req), .L1_data(L1_data), .L1_ack(L1_ack),
      .R_req(R_req), .R_data(R_data), .R_src(R_src), .R_ack(R_ack)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   logic [8:0] q[$];
   int cyc = 0, r_hs = 0, l0_rises = 0, l1_rises = 0, l0_rise_cyc = 0, l1_rise_cyc = 0;
   logic r_prev = 1'b0, l0_prev = 1'b0, l1_prev = 1'b0;

   // Output monitor and immediate-ack consumer, sampled 1 time unit after each edge.
   initial forever begin
      @(posedge clk); #1;
      cyc++;
      if (R_req === 1'b1 && r_prev !== 1'b1) begin q.push_back({R_src, R_data}); r_hs++; end
      if (L0_ack === 1'b1 && l0_prev !== 1'b1) begin l0_rises++; l0_rise_cyc = cyc; end
      if (L1_ack === 1'b1 && l1_prev !== 1'b1) begin l1_rises++; l1_rise_cyc = cyc; end
      r_prev   = R_req;
      l0_prev  = L0_ack;
      l1_prev  = L1_ack;
      cons_ack = (R_req === 1'b1);
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #2;
   endtask

   function automatic logic ack_of(input bit ch);
      return ch ? L1_ack : L0_ack;
   endfunction

   task automatic send(input bit ch, input logic [7:0] d);
      int k;
      if (ch) begin L1_data = d; L1_req = 1'b1; end
      else    begin L0_data = d; L0_req = 1'b1; end
      k = 0;
      while (ack_of(ch) !== 1'b1 && k < 200) begin step(); k++; end
      check($sformatf("ack_rise%0d_%0h", ch, d), {15'd0, ack_of(ch)}, 16'd1);
      if (ch) L1_req = 1'b0; else L0_req = 1'b0;
      k = 0;
      while (ack_of(ch) !== 1'b0 && k < 200) begin step(); k++; end
      check($sformatf("ack_fall%0d_%0h", ch, d), {15'd0, ack_of(ch)}, 16'd0);
   endtask

   task automatic wait_q(input int n);
      int k = 0;
      while (q.size() < n && k < 400) begin step(); k++; end
      check("drain_count", 16'(q.size()), 16'(n));
      repeat (4) step();
   endtask

   task automatic do_reset();
      cons_en = 1'b0;
      man_ack = 1'b0;
      L0_req  = 1'b0;
      L1_req  = 1'b0;
      rst     = 1'b1;
      step(); step();
      rst     = 1'b0;
   endtask

   initial begin
      int base, hs0, r0, r1;
      logic [8:0] exp_w;

      // Reset state
      do_reset();
      check("rst_L0_ack", {15'd0, L0_ack}, 16'd0);
      check("rst_L1_ack", {15'd0, L1_ack}, 16'd0);
      check("rst_R_req",  {15'd0, R_req},  16'd0);
      check("rst_R_data", {8'd0, R_data},  16'd0);
      check("rst_R_src",  {15'd0, R_src},  16'd0);
      check("rst_count",  16'(dut.count),  16'd0);
      check("rst_rr",     {15'd0, dut.rr}, 16'd0);

      // Single source
      cons_en = 1'b1;
      base = q.size(); hs0 = r_hs; r0 = l0_rises; r1 = l1_rises;
      send(1'b0, 8'h5A);
      wait_q(base + 1);
      check("single_word", 16'(q[base]), 16'h05A);
      check("single_hs",   16'(r_hs - hs0), 16'd1);
      check("single_l0",   16'(l0_rises - r0), 16'd1);
      check("single_l1",   16'(l1_rises - r1), 16'd0);

      // Contention straight after reset
      do_reset();
      cons_en = 1'b1;
      base = q.size();
      fork
         send(1'b0, 8'h11);
         send(1'b1, 8'h22);
      join
      wait_q(base + 2);
      check("cont_first",  16'(q[base]),     16'h011);
      check("cont_second", 16'(q[base + 1]), 16'h122);
      check("cont_gap",    16'(l1_rise_cyc - l0_rise_cyc), 16'd1);
      check("cont_rr",     {15'd0, dut.rr}, 16'd1);

      // Fairness: two continuous streams of 8 words
      do_reset();
      cons_en = 1'b1;
      base = q.size();
      fork
         for (int i = 0; i < 8; i++) send(1'b0, 8'h10 + 8'(i));
         for (int i = 0; i < 8; i++) send(1'b1, 8'h20 + 8'(i));
      join
      wait_q(base + 16);
      for (int i = 0; i < 16; i++) begin
         exp_w = (i % 2 == 1) ? {1'b1, 8'h20 + 8'(i / 2)} : {1'b0, 8'h10 + 8'(i / 2)};
         check($sformatf("fair_%0d", i), 16'(q[base + i]), 16'(exp_w));
      end

      // Backpressure: buffer full, L1 must wait
      do_reset();
      base = q.size();
      send(1'b0, 8'h01);
      send(1'b0, 8'h02);
      check("bp_full_count", 16'(dut.count), 16'd2);
      L1_data = 8'h03; L1_req = 1'b1;
      repeat (3) step();
      check("bp_l1_wait",  {15'd0, L1_ack}, 16'd0);
      check("bp_count",    16'(dut.count), 16'd2);
      check("bp_head",     {8'd0, R_data}, 16'h01);
      man_ack = 1'b1;
      step();
      check("bp_l1_accept", {15'd0, L1_ack}, 16'd1);
      man_ack = 1'b0; L1_req = 1'b0;
      step();
      cons_en = 1'b1;
      wait_q(base + 3);
      check("bp_w0", 16'(q[base]),     16'h001);
      check("bp_w1", 16'(q[base + 1]), 16'h002);
      check("bp_w2", 16'(q[base + 2]), 16'h103);

      // Push and pop on the same edge at full
      do_reset();
      base = q.size();
      send(1'b0, 8'h31);
      send(1'b0, 8'h32);
      check("pp_pre_count", 16'(dut.count), 16'd2);
      check("pp_pre_req",   {15'd0, R_req}, 16'd1);
      L1_data = 8'h33; L1_req = 1'b1; man_ack = 1'b1;
      step();
      check("pp_count", 16'(dut.count), 16'd2);
      check("pp_l1_ack", {15'd0, L1_ack}, 16'd1);
      check("pp_r_req",  {15'd0, R_req}, 16'd0);
      man_ack = 1'b0; L1_req = 1'b0;
      step();
      cons_en = 1'b1;
      wait_q(base + 3);
      check("pp_w0", 16'(q[base]),     16'h031);
      check("pp_w1", 16'(q[base + 1]), 16'h032);
      check("pp_w2", 16'(q[base + 2]), 16'h133);

      // Reset in the middle of open handshakes
      do_reset();
      L0_data = 8'h44; L0_req = 1'b1;
      step(); step();
      check("mid_pre_l0_ack", {15'd0, L0_ack}, 16'd1);
      check("mid_pre_r_req",  {15'd0, R_req},  16'd1);
      rst = 1'b1; L0_req = 1'b0;
      step();
      check("mid_l0_ack", {15'd0, L0_ack}, 16'd0);
      check("mid_l1_ack", {15'd0, L1_ack}, 16'd0);
      check("mid_r_req",  {15'd0, R_req},  16'd0);
      check("mid_count",  16'(dut.count),  16'd0);
      rst = 1'b0;
      step();
      base = q.size();
      cons_en = 1'b1;
      send(1'b0, 8'h7F);
      wait_q(base + 1);
      check("mid_after_word", 16'(q[base]), 16'h07F);
      check("mid_after_count", 16'(dut.count), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
